// File: rtl/readburst_arbiter_pkg.sv
// Shared readburst field widths, FSM encodings and the request record captured at grant.
package readburst_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int DWLEN_W = 2;
    localparam int BLEN_W  = 4;
    localparam int DATA_W  = 96;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  address;
        logic [DWLEN_W-1:0] dword_length;
        logic [BLEN_W-1:0]  byte_length;
    } rb_req_t;

endpackage

// File: rtl/readburst_rr_pick.sv
// Two-way requester pick: fixed port-0 priority or alternate against last_owner.
// Purely combinational; valid is high whenever either port requests.
module readburst_rr_pick #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = req1;
        if (req0 && req1) begin
            winner = (ROUND_ROBIN != 0) ? ~last_owner : 1'b0;
        end
    end

endmodule

// File: rtl/readburst_arbiter.sv
// Arbitrates two readburst requesters onto one downstream burst port; grant latency one cycle.
// The grant is held from a saved copy of the request until the downstream done, which is routed back to the owner.
module readburst_arbiter
    import readburst_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int WDOG_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_readburst_do,
    output logic               req0_readburst_done,
    input  logic [ADDR_W-1:0]  req0_readburst_address,
    input  logic [DWLEN_W-1:0] req0_readburst_dword_length,
    input  logic [BLEN_W-1:0]  req0_readburst_byte_length,
    output logic [DATA_W-1:0]  req0_readburst_data,
    input  logic               req1_readburst_do,
    output logic               req1_readburst_done,
    input  logic [ADDR_W-1:0]  req1_readburst_address,
    input  logic [DWLEN_W-1:0] req1_readburst_dword_length,
    input  logic [BLEN_W-1:0]  req1_readburst_byte_length,
    output logic [DATA_W-1:0]  req1_readburst_data,
    output logic               resp_readburst_do,
    input  logic               resp_readburst_done,
    output logic [ADDR_W-1:0]  resp_readburst_address,
    output logic [DWLEN_W-1:0] resp_readburst_dword_length,
    output logic [BLEN_W-1:0]  resp_readburst_byte_length,
    input  logic [DATA_W-1:0]  resp_readburst_data,
    output logic               wdog_err,
    output logic               busy_owner
);

    state_t              state;
    logic                owner;
    logic                last_owner;
    rb_req_t             saved;
    logic [WDOG_W-1:0]   wdog;
    logic [WDOG_W-1:0]   wdog_inc;
    logic                wdog_err_q;
    logic                pick_valid;
    logic                pick_winner;
    logic                done_fire;
    rb_req_t             req0_f;
    rb_req_t             req1_f;

    assign req0_f   = '{req0_readburst_address, req0_readburst_dword_length, req0_readburst_byte_length};
    assign req1_f   = '{req1_readburst_address, req1_readburst_dword_length, req1_readburst_byte_length};
    assign wdog_inc = wdog + 1'b1;

    readburst_rr_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req0       (req0_readburst_do),
        .req1       (req1_readburst_do),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // A done coinciding with reset belongs to an abandoned burst, so it is swallowed.
    assign done_fire = (state == ST_BUSY) && resp_readburst_done && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            saved      <= '0;
            wdog       <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_winner;
                        saved <= pick_winner ? req1_f : req0_f;
                        wdog  <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (resp_readburst_done) begin
                        last_owner <= owner;
                        wdog       <= '0;
                        state      <= ST_IDLE;
                    end else if (wdog != '1) begin
                        // Saturate and flag; the burst itself is left running.
                        wdog <= wdog_inc;
                        if (wdog_inc == '1) begin
                            wdog_err_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign resp_readburst_do           = (state == ST_BUSY);
    assign resp_readburst_address      = saved.address;
    assign resp_readburst_dword_length = saved.dword_length;
    assign resp_readburst_byte_length  = saved.byte_length;
    assign req0_readburst_done         = done_fire && !owner;
    assign req1_readburst_done         = done_fire && owner;
    assign req0_readburst_data         = resp_readburst_data;
    assign req1_readburst_data         = resp_readburst_data;
    assign wdog_err                    = wdog_err_q;
    assign busy_owner                  = owner;

endmodule

// File: tb/tb_readburst_arbiter.sv
// Directed bench for readburst_arbiter: round-robin instance plus a fixed-priority instance on shared inputs.
module tb_readburst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_do, r1_do, resp_done;
    logic [31:0] r0_addr, r1_addr;
    logic [1:0]  r0_dw, r1_dw;
    logic [3:0]  r0_bl, r1_bl;
    logic [95:0] resp_data;

    logic        d0, d1, rdo, werr, bown;
    logic [95:0] dat0, dat1;
    logic [31:0] raddr;
    logic [1:0]  rdw;
    logic [3:0]  rbl;

    logic        fp_d0, fp_d1, fp_rdo, fp_werr, fp_bown;
    logic [95:0] fp_dat0, fp_dat1;
    logic [31:0] fp_raddr;
    logic [1:0]  fp_rdw;
    logic [3:0]  fp_rbl;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [95:0] DATA_A5 = {12{8'hA5}};

    always #5 clk = ~clk;

    readburst_arbiter #(.ROUND_ROBIN(1), .WDOG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_readburst_do(r0_do), .req0_readburst_done(d0),
        .req0_readburst_address(r0_addr), .req0_readburst_dword_length(r0_dw),
        .req0_readburst_byte_length(r0_bl), .req0_readburst_data(dat0),
        .req1_readburst_do(r1_do), .req1_readburst_done(d1),
        .req1_readburst_address(r1_addr), .req1_readburst_dword_length(r1_dw),
        .req1_readburst_byte_length(r1_bl), .req1_readburst_data(dat1),
        .resp_readburst_do(rdo), .resp_readburst_done(resp_done),
        .resp_readburst_address(raddr), .resp_readburst_dword_length(rdw),
        .resp_readburst_byte_length(rbl), .resp_readburst_data(resp_data),
        .wdog_err(werr), .busy_owner(bown)
    );

    readburst_arbiter #(.ROUND_ROBIN(0), .WDOG_W(4)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_readburst_do(r0_do), .req0_readburst_done(fp_d0),
        .req0_readburst_address(r0_addr), .req0_readburst_dword_length(r0_dw),
        .req0_readburst_byte_length(r0_bl), .req0_readburst_data(fp_dat0),
        .req1_readburst_do(r1_do), .req1_readburst_done(fp_d1),
        .req1_readburst_address(r1_addr), .req1_readburst_dword_length(r1_dw),
        .req1_readburst_byte_length(r1_bl), .req1_readburst_data(fp_dat1),
        .resp_readburst_do(fp_rdo), .resp_readburst_done(resp_done),
        .resp_readburst_address(fp_raddr), .resp_readburst_dword_length(fp_rdw),
        .resp_readburst_byte_length(fp_rbl), .resp_readburst_data(resp_data),
        .wdog_err(fp_werr), .busy_owner(fp_bown)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        r0_do     = 1'b0;
        r1_do     = 1'b0;
        resp_done = 1'b0;
        r0_addr   = 32'h0000_1000;
        r1_addr   = 32'h0000_2000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r0, r1, done;
        logic        exp_do, exp_owner, exp_d0, exp_d1;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[14];

    initial begin
        rst       = 1'b1;
        r0_do     = 1'b0;
        r1_do     = 1'b0;
        resp_done = 1'b0;
        r0_addr   = 32'h0000_1000;
        r0_dw     = 2'd2;
        r0_bl     = 4'd8;
        r1_addr   = 32'h0000_2000;
        r1_dw     = 2'd1;
        r1_bl     = 4'd4;
        resp_data = DATA_A5;

        // Cycle-by-cycle round-robin sequence, starting right after reset.
        //          r0    r1    done  do    own   d0    d1    addr
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};

        // Reset state and single request with mid-burst field change.
        do_reset();
        #1;
        chk("rst_resp_do", {95'd0, rdo}, 96'd0);
        chk("rst_resp_addr", {64'd0, raddr}, 96'd0);
        chk("rst_resp_dw", {94'd0, rdw}, 96'd0);
        chk("rst_resp_bl", {92'd0, rbl}, 96'd0);
        chk("rst_dones", {94'd0, d0, d1}, 96'd0);
        chk("rst_busy_owner", {95'd0, bown}, 96'd0);
        chk("rst_wdog_err", {95'd0, werr}, 96'd0);

        @(negedge clk); r0_do = 1'b1; #1;
        chk("single_do_lat0", {95'd0, rdo}, 96'd0);
        @(negedge clk); #1;
        chk("single_do_lat1", {95'd0, rdo}, 96'd1);
        chk("single_addr", {64'd0, raddr}, 96'h1000);
        chk("single_dw", {94'd0, rdw}, 96'd2);
        chk("single_bl", {92'd0, rbl}, 96'd8);
        @(negedge clk); r0_addr = 32'h0000_3000; #1;
        chk("stable_addr_a", {64'd0, raddr}, 96'h1000);
        @(negedge clk); #1;
        chk("stable_addr_b", {64'd0, raddr}, 96'h1000);
        @(negedge clk); resp_done = 1'b1; #1;
        chk("single_done0", {95'd0, d0}, 96'd1);
        chk("single_done1", {95'd0, d1}, 96'd0);
        chk("single_data0", dat0, DATA_A5);
        chk("stable_addr_done", {64'd0, raddr}, 96'h1000);
        @(negedge clk); resp_done = 1'b0; r0_do = 1'b0; r0_addr = 32'h0000_1000; #1;
        chk("single_after_do", {95'd0, rdo}, 96'd0);
        chk("single_after_d0", {95'd0, d0}, 96'd0);

        // Round-robin table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            r0_do     = vt[i].r0;
            r1_do     = vt[i].r1;
            resp_done = vt[i].done;
            #1;
            chk($sformatf("rr_do[%0d]", i), {95'd0, rdo}, {95'd0, vt[i].exp_do});
            chk($sformatf("rr_owner[%0d]", i), {95'd0, bown}, {95'd0, vt[i].exp_owner});
            chk($sformatf("rr_d0[%0d]", i), {95'd0, d0}, {95'd0, vt[i].exp_d0});
            chk($sformatf("rr_d1[%0d]", i), {95'd0, d1}, {95'd0, vt[i].exp_d1});
            chk($sformatf("rr_addr[%0d]", i), {64'd0, raddr}, {64'd0, vt[i].exp_addr});
            if (vt[i].exp_d1) chk($sformatf("rr_data1[%0d]", i), dat1, DATA_A5);
        end

        // Fixed priority: port 0 requests every cycle, port 1 must starve.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            r0_do     = 1'b1;
            r1_do     = 1'b1;
            resp_done = (c % 3 == 2);
            #1;
            chk($sformatf("fp_do[%0d]", c), {95'd0, fp_rdo}, {95'd0, (c % 3 != 0)});
            chk($sformatf("fp_owner[%0d]", c), {95'd0, fp_bown}, 96'd0);
            chk($sformatf("fp_d1[%0d]", c), {95'd0, fp_d1}, 96'd0);
            chk($sformatf("fp_d0[%0d]", c), {95'd0, fp_d0}, {95'd0, (c % 3 == 2)});
        end

        // Reset mid-burst with a coincident downstream done.
        do_reset();
        @(negedge clk); r0_do = 1'b1; #1;
        @(negedge clk); #1;
        chk("rstmid_busy", {95'd0, rdo}, 96'd1);
        @(negedge clk); rst = 1'b1; resp_done = 1'b1; r0_do = 1'b0; #1;
        chk("rstmid_no_d0", {95'd0, d0}, 96'd0);
        chk("rstmid_no_d1", {95'd0, d1}, 96'd0);
        @(negedge clk); rst = 1'b0; resp_done = 1'b0; #1;
        chk("rstmid_idle_do", {95'd0, rdo}, 96'd0);
        chk("rstmid_idle_d0", {95'd0, d0}, 96'd0);

        // Watchdog with a 4-bit counter: flag after 15 busy cycles, sticky until reset.
        do_reset();
        @(negedge clk); r0_do = 1'b1; #1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); #1;
        end
        chk("wdog_pre", {95'd0, werr}, 96'd0);
        @(negedge clk); #1;
        chk("wdog_set", {95'd0, werr}, 96'd1);
        chk("wdog_no_abort", {95'd0, rdo}, 96'd1);
        @(negedge clk); resp_done = 1'b1; #1;
        chk("wdog_late_d0", {95'd0, d0}, 96'd1);
        @(negedge clk); resp_done = 1'b0; r0_do = 1'b0; #1;
        chk("wdog_sticky", {95'd0, werr}, 96'd1);
        chk("wdog_idle_do", {95'd0, rdo}, 96'd0);
        do_reset();
        #1;
        chk("wdog_clear", {95'd0, werr}, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/readburst_arbiter.md
Name: readburst_arbiter

Overview:
- Shares one readburst response port between two requesters: port 0 (data read path) and port 1 (code prefetch path).
- Sits in the memory block between the read/prefetch request sources and the downstream burst engine.
- Grants one requester at a time and saves that requester's address and lengths at grant.
- Holds the grant and drives the downstream port from the saved copy until the downstream done pulse, then routes done and data back to the owner.

Parameters:
- ROUND_ROBIN, 1, 1 selects alternating priority on simultaneous requests; 0 gives port 0 fixed priority.
- WDOG_W, 8, width of the busy-cycle watchdog counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_readburst_do  in  1  port 0 request; held high until req0_readburst_done
- req0_readburst_done  out  1  one-cycle completion pulse to port 0
- req0_readburst_address  in  32  port 0 byte address
- req0_readburst_dword_length  in  2  port 0 dword count
- req0_readburst_byte_length  in  4  port 0 byte count
- req0_readburst_data  out  96  port 0 read data; valid only with done
- req1_readburst_do / _done / _address / _dword_length / _byte_length / _data  same as port 0, for port 1
- resp_readburst_do  out  1  downstream request
- resp_readburst_done  in  1  downstream one-cycle completion
- resp_readburst_address  out  32  downstream address
- resp_readburst_dword_length  out  2  downstream dword count
- resp_readburst_byte_length  out  4  downstream byte count
- resp_readburst_data  in  96  downstream data, valid with done
- wdog_err  out  1  sticky: a burst exceeded 2^WDOG_W-1 busy cycles
- busy_owner  out  1  owner of the current or most recent grant (0 or 1)

Behaviour:
- States: IDLE, BUSY. Registers:
  - state
  - owner
  - last_owner
  - saved address, dword_length and byte_length
  - wdog counter
  - wdog_err
- Reset (rst high at a clk edge): state=IDLE; owner=0; last_owner=1; saved fields=0; wdog=0; wdog_err=0.
  - Outputs after reset: resp_readburst_do=0, resp fields=0, both req dones=0, busy_owner=0.
  - Reset mid-BUSY abandons the burst. A resp_readburst_done arriving in the same cycle as reset is not forwarded.
- IDLE:
  - If any reqN_do is high, pick the winner, save its fields, set owner, go to BUSY.
  - Winner when only one port requests: that port.
  - Winner when both request: with ROUND_ROBIN=1, the port != last_owner; with ROUND_ROBIN=0, port 0.
  - No request: stay in IDLE.
- Latency: resp_readburst_do rises 1 cycle after the winning reqN_do is first sampled high in IDLE.
- BUSY:
  - resp_readburst_do=1 and the resp fields are driven from the saved registers only. Requester field changes mid-burst are ignored.
  - wdog increments each cycle and saturates at all-ones. Reaching all-ones sets wdog_err, which clears only on reset. The burst is not aborted.
  - On resp_readburst_done: the owner's req_done=1 in that same cycle (combinational); the other port's done stays 0.
  - Also on done: req_data of both ports = resp_readburst_data (owner qualifies it with done); last_owner=owner; wdog=0; state=IDLE.
- Back-to-back: IDLE is always visited for one cycle, so the minimum gap is one idle cycle between resp_do pulses.
  - The loser of arbitration is granted in the cycle after the winner's done.
- Requester drops do during BUSY (protocol violation): the burst completes anyway and done is still pulsed to that port.
- resp_readburst_done while in IDLE is ignored; no req done is generated.
- busy_owner = owner register.

Decomposition:
- Shared memory package constants:
  - state encodings ST_IDLE / ST_BUSY
  - readburst field widths: address 32, dword length 2, byte length 4, data 96
- One natural sub-module: readburst_rr_pick. It is combinational, takes (req0, req1, last_owner, ROUND_ROBIN), and returns (valid, winner).
- Save registers, FSM and watchdog stay in the top module.

Test Plan:
- Single request: port 0 requests addr 0x0000_1000, dwords 2, bytes 8; downstream done with data 0xA5.. 3 cycles after resp_do.
  - resp_do rises 1 cycle after req0_do with the same fields.
  - req0_done pulses one cycle with data 0xA5.. ; req1_done stays 0.
- Simultaneous request, ROUND_ROBIN=1, after reset: port 0 granted first (last_owner=1); port 1 (addr 0x2000) granted on the cycle after port 0's done.
  - A second simultaneous pair is ordered port 1 then port 0.
- ROUND_ROBIN=0 with port 0 re-requesting continuously: port 1 is never granted while port 0 requests in every IDLE cycle.
- Field stability: port 0 changes its address from 0x1000 to 0x3000 mid-BUSY; resp_address stays 0x1000 until done.
- Reset mid-BUSY with done asserted in the same cycle: no req done is emitted; the next cycle is IDLE with resp_do=0.
- Watchdog, WDOG_W=4: downstream never asserts done; wdog_err rises at 15 busy cycles, stays high after a later done, and clears only on rst.
